// File: rtl/control_unit.sv
// control_unit: hardwired T-step control sequencer for the phase-2 CPU.
// Define CU_MULDIV_EN to enable mul/div; otherwise they decode as illegal.
module control_unit (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        CON,
    input  logic        stop,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        MDRread,
    output logic        RAMwrite,
    output logic        IRin,
    output logic        RYin,
    output logic        RZinLo,
    output logic        RZinHi,
    output logic        RZoutLo,
    output logic        RZoutHi,
    output logic        HIin,
    output logic        LOin,
    output logic        HIout,
    output logic        LOout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        RCout,
    output logic        CONin,
    output logic        InPortOut,
    output logic        OutPortIn,
    output logic        run,
    output logic        illegal
);
    typedef enum logic [3:0] {
        S_T0    = 4'd0,
        S_T1    = 4'd1,
        S_T2    = 4'd2,
        S_T3    = 4'd3,
        S_T4    = 4'd4,
        S_T5    = 4'd5,
        S_T6    = 4'd6,
        S_T7    = 4'd7,
        S_RESET = 4'd8,
        S_HALT  = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] op;
    logic [2:0] last_step;
    logic       at_last;
    logic       c_alu, c_imm, c_md, c_neg, c_ld, c_ldi, c_st, c_br;
    logic       c_jr, c_jal, c_in, c_out, c_mfhi, c_mflo, c_nop, c_halt, c_ill;

    assign op      = IR[31:27];
    assign at_last = (state_q[2:0] == last_step);

    // Opcode classification; only consulted from T3 onward
    always_comb begin
        c_alu = 1'b0; c_imm = 1'b0; c_md = 1'b0; c_neg = 1'b0;
        c_ld = 1'b0; c_ldi = 1'b0; c_st = 1'b0; c_br = 1'b0;
        c_jr = 1'b0; c_jal = 1'b0; c_in = 1'b0; c_out = 1'b0;
        c_mfhi = 1'b0; c_mflo = 1'b0; c_nop = 1'b0; c_halt = 1'b0;
        c_ill = 1'b0;
        case (op)
            5'd0:  c_ld = 1'b1;
            5'd1:  c_ldi = 1'b1;
            5'd2:  c_st = 1'b1;
            5'd3, 5'd4, 5'd5, 5'd6,
            5'd7, 5'd8, 5'd9, 5'd10: c_alu = 1'b1;
            5'd11, 5'd12, 5'd13: c_imm = 1'b1;
            5'd14, 5'd15: begin
`ifdef CU_MULDIV_EN
                c_md = 1'b1;
`else
                c_ill = 1'b1;
`endif
            end
            5'd16, 5'd17: c_neg = 1'b1;
            5'd18: c_br = 1'b1;
            5'd19: c_jr = 1'b1;
            5'd20: c_jal = 1'b1;
            5'd21: c_in = 1'b1;
            5'd22: c_out = 1'b1;
            5'd23: c_mfhi = 1'b1;
            5'd24: c_mflo = 1'b1;
            5'd25: c_nop = 1'b1;
            5'd26: c_halt = 1'b1;
            default: c_ill = 1'b1;
        endcase
    end

    // Final T-step index of the current instruction
    always_comb begin
        last_step = 3'd3;
        if (c_ld || c_st)
            last_step = 3'd7;
        else if (c_md || c_br)
            last_step = 3'd6;
        else if (c_alu || c_imm || c_ldi)
            last_step = 3'd5;
        else if (c_neg || c_jal)
            last_step = 3'd4;
    end

    // Next T-step: fetch always runs T0-T2, execute ends at last_step
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RESET: state_d = S_T0;
            S_HALT:  state_d = S_HALT;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (at_last)
                    state_d = (c_halt || stop) ? S_HALT : S_T0;
                else
                    state_d = state_t'(state_q + 4'd1);
            end
            default: state_d = S_RESET;
        endcase
    end

    // State register with synchronous clear
    always_ff @(posedge clock) begin
        if (clear)
            state_q <= S_RESET;
        else
            state_q <= state_d;
    end

    // Moore control decode of T-step and opcode; forced quiet during clear
    always_comb begin
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; MDRread = 1'b0; RAMwrite = 1'b0;
        IRin = 1'b0; RYin = 1'b0; RZinLo = 1'b0; RZinHi = 1'b0;
        RZoutLo = 1'b0; RZoutHi = 1'b0; HIin = 1'b0; LOin = 1'b0;
        HIout = 1'b0; LOout = 1'b0; Gra = 1'b0; Grb = 1'b0;
        Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
        RCout = 1'b0; CONin = 1'b0; InPortOut = 1'b0; OutPortIn = 1'b0;
        run = 1'b0; illegal = 1'b0;
        if (!clear) begin
            unique case (state_q)
                S_T0: begin
                    run = 1'b1;
                    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; RZinLo = 1'b1;
                end
                S_T1: begin
                    run = 1'b1;
                    RZoutLo = 1'b1; PCin = 1'b1; MDRread = 1'b1; MDRin = 1'b1;
                end
                S_T2: begin
                    run = 1'b1;
                    MDRout = 1'b1; IRin = 1'b1;
                end
                S_T3: begin
                    run = 1'b1;
                    if (c_alu || c_imm) begin Grb = 1'b1; Rout = 1'b1; RYin = 1'b1; end
                    if (c_md) begin Gra = 1'b1; Rout = 1'b1; RYin = 1'b1; end
                    if (c_neg) begin Grb = 1'b1; Rout = 1'b1; RZinLo = 1'b1; end
                    if (c_ld || c_ldi || c_st) begin Grb = 1'b1; BAout = 1'b1; RYin = 1'b1; end
                    if (c_br) begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    if (c_jr) begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    if (c_in) begin InPortOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    if (c_out) begin Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1; end
                    if (c_mfhi) begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    if (c_mflo) begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    if (c_jal) begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
                    if (c_ill) illegal = 1'b1;
                end
                S_T4: begin
                    run = 1'b1;
                    if (c_alu) begin Grc = 1'b1; Rout = 1'b1; RZinLo = 1'b1; end
                    if (c_imm || c_ld || c_ldi || c_st) begin RCout = 1'b1; RZinLo = 1'b1; end
                    if (c_md) begin Grb = 1'b1; Rout = 1'b1; RZinLo = 1'b1; RZinHi = 1'b1; end
                    if (c_neg) begin RZoutLo = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    if (c_br) begin PCout = 1'b1; RYin = 1'b1; end
                    if (c_jal) begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                end
                S_T5: begin
                    run = 1'b1;
                    if (c_alu || c_imm || c_ldi) begin RZoutLo = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    if (c_md) begin RZoutLo = 1'b1; LOin = 1'b1; end
                    if (c_ld || c_st) begin RZoutLo = 1'b1; MARin = 1'b1; end
                    if (c_br) begin RCout = 1'b1; RZinLo = 1'b1; end
                end
                S_T6: begin
                    run = 1'b1;
                    if (c_md) begin RZoutHi = 1'b1; HIin = 1'b1; end
                    if (c_ld) begin MDRread = 1'b1; MDRin = 1'b1; end
                    if (c_st) begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    if (c_br) begin RZoutLo = 1'b1; PCin = CON; end
                end
                S_T7: begin
                    run = 1'b1;
                    if (c_ld) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    if (c_st) RAMwrite = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
